// File: rtl/vreg_file_lanes.sv
// ----------------------------------------------------------------------------
// vreg_file_lanes
//   Multi-lane vector register file for the VMIPS SIMD datapath. Each of the
//   NUM_REGS registers holds LANES elements of ELEM_W bits. Writes are masked
//   per lane, reads are combinational with optional same-cycle write bypass,
//   and a sequential clear engine zeroes one register per cycle on request.
//
// Ports
//   clk           in   clock, all state updates on posedge
//   rst           in   synchronous active-high reset
//   rd_addr1/2    in   read port addresses
//   rd_data1/2    out  read port data, lane i = bits [i*ELEM_W +: ELEM_W]
//   wr_en         in   write request
//   wr_addr       in   write address
//   wr_lane_mask  in   per-lane write enable
//   wr_data       in   write data
//   clr_req       in   start a full-file clear (ignored unless idle)
//   clr_busy      out  high while the clear engine is zeroing registers
//   clr_done      out  one-cycle pulse after the last register is zeroed
//   dbg_state     out  clear FSM state, for observation only
//
// Handshake: clr_req is sampled only in IDLE; it does not queue. clr_busy is
// high for exactly NUM_REGS cycles, followed by a single clr_done cycle.
// Writes are accepted only in IDLE; any other write is dropped silently.
// ----------------------------------------------------------------------------
module vreg_file_lanes #(
    parameter int NUM_REGS = 32,
    parameter int LANES    = 4,
    parameter int ELEM_W   = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS),
    localparam int DW      = LANES * ELEM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [DW-1:0]    rd_data1,
    output logic [DW-1:0]    rd_data2,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [LANES-1:0] wr_lane_mask,
    input  logic [DW-1:0]    wr_data,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_done,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [AW:0]   NUM_REGS_W = (AW+1)'(NUM_REGS);
    localparam logic [AW-1:0] LAST_REG   = AW'(NUM_REGS - 1);

    logic [DW-1:0] r_mem [NUM_REGS];
    logic [1:0]    r_state;
    logic [AW-1:0] r_clr_cnt;

    // Address is in range and not the hardwired zero register.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return ({1'b0, a} < NUM_REGS_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // A write is accepted only when idle; this same term gates the bypass,
    // so nothing is forwarded while clearing or in DONE.
    logic w_wr_ok;
    assign w_wr_ok = wr_en && (r_state == ST_IDLE) && addr_live(wr_addr);

    // ------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == LAST_REG) begin
                        r_state   <= ST_DONE;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + AW'(1);
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign clr_busy  = (r_state == ST_CLEAR);
    assign clr_done  = (r_state == ST_DONE);
    assign dbg_state = r_state;

    // ------------------------------------------------------------------
    // Storage: masked writes and clear engine never coincide, since writes
    // need IDLE and the clear runs only in CLEAR.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            if (w_wr_ok) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wr_lane_mask[l]) begin
                        r_mem[wr_addr][l*ELEM_W +: ELEM_W] <= wr_data[l*ELEM_W +: ELEM_W];
                    end
                end
            end
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational read ports with per-lane bypass
    // ------------------------------------------------------------------
    logic [DW-1:0] w_raw1;
    logic [DW-1:0] w_raw2;
    logic          w_hit1;
    logic          w_hit2;

    assign w_raw1 = addr_live(rd_addr1) ? r_mem[rd_addr1] : '0;
    assign w_raw2 = addr_live(rd_addr2) ? r_mem[rd_addr2] : '0;
    assign w_hit1 = (BYPASS != 0) && w_wr_ok && (rd_addr1 == wr_addr);
    assign w_hit2 = (BYPASS != 0) && w_wr_ok && (rd_addr2 == wr_addr);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign rd_data1[g*ELEM_W +: ELEM_W] = (w_hit1 && wr_lane_mask[g]) ?
            wr_data[g*ELEM_W +: ELEM_W] : w_raw1[g*ELEM_W +: ELEM_W];
        assign rd_data2[g*ELEM_W +: ELEM_W] = (w_hit2 && wr_lane_mask[g]) ?
            wr_data[g*ELEM_W +: ELEM_W] : w_raw2[g*ELEM_W +: ELEM_W];
    end

endmodule

// File: tb/tb_vreg_file_lanes.sv
module tb_vreg_file_lanes;

  localparam int NR = 32;
  localparam int LN = 4;
  localparam int EW = 32;
  localparam int AW = 5;
  localparam int W  = LN * EW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic [W-1:0]  rd_data1, rd_data2;
  logic [W-1:0]  nb_rd_data1, nb_rd_data2;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [LN-1:0] wr_lane_mask;
  logic [W-1:0]  wr_data;
  logic          clr_req;
  logic          clr_busy, clr_done;
  logic          nb_clr_busy, nb_clr_done;
  logic [1:0]    dbg_state, nb_dbg_state;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model [NR];

  vreg_file_lanes #(.NUM_REGS(NR), .LANES(LN), .ELEM_W(EW), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_mask(wr_lane_mask), .wr_data(wr_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .dbg_state(dbg_state)
  );

  // Second copy without bypass, fed the same stimulus.
  vreg_file_lanes #(.NUM_REGS(NR), .LANES(LN), .ELEM_W(EW), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(nb_rd_data1), .rd_data2(nb_rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_mask(wr_lane_mask), .wr_data(wr_data),
    .clr_req(clr_req), .clr_busy(nb_clr_busy), .clr_done(nb_clr_done), .dbg_state(nb_dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard read: expected pushed when the address is driven, popped
  // when the combinational output has settled
  task automatic sb_read(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    rd_addr1 = a;
    rd_addr2 = a;
    #1;
    check({tag, "_p1"}, rd_data1, exp_q.pop_front());
  endtask

  task automatic drv_write(input logic [AW-1:0] a, input logic [LN-1:0] m, input logic [W-1:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_lane_mask = m;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  int busy_cnt, done_cnt, done_at, c;
  logic [W-1:0] v;

  initial begin
    rst = 1'b1; rd_addr1 = '0; rd_addr2 = '0; wr_en = 1'b0; wr_addr = '0;
    wr_lane_mask = '0; wr_data = '0; clr_req = 1'b0;
    for (int r = 0; r < NR; r++) model[r] = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    check("rst_busy", W'(clr_busy), W'(0));
    check("rst_done", W'(clr_done), W'(0));
    for (int r = 0; r < NR; r++) sb_read($sformatf("rst_reg%0d", r), AW'(r), '0);

    // zero register and plain write
    drv_write(5'd0, 4'hF, {LN{32'hFFFF_FFFF}});
    drv_write(5'd5, 4'hF, {LN{32'hFFFF_FFFF}});
    model[5] = {LN{32'hFFFF_FFFF}};
    sb_read("zero_reg0", 5'd0, '0);
    sb_read("wr_reg5", 5'd5, model[5]);
    rd_addr2 = 5'd5; rd_addr1 = 5'd0; #1;
    check("wr_reg5_p2", rd_data2, model[5]);

    // lane mask
    drv_write(5'd7, 4'hF, {LN{32'h1111_1111}});
    drv_write(5'd7, 4'b0101, {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA});
    model[7] = {32'h1111_1111, 32'hCCCC_CCCC, 32'h1111_1111, 32'hAAAA_AAAA};
    sb_read("lane_mask", 5'd7, model[7]);

    // bypass: check combinationally before the edge
    drv_write(5'd3, 4'hF, {LN{32'h5}});
    wr_en = 1'b1; wr_addr = 5'd3; wr_lane_mask = 4'b0011; wr_data = {LN{32'h9}};
    rd_addr1 = 5'd3; rd_addr2 = 5'd7; #1;
    check("bypass_on", rd_data1, {32'h5, 32'h5, 32'h9, 32'h9});
    check("bypass_off", nb_rd_data1, {LN{32'h5}});
    check("bypass_other_port", rd_data2, model[7]);
    tick();
    wr_en = 1'b0;
    model[3] = {32'h5, 32'h5, 32'h9, 32'h9};
    sb_read("bypass_commit", 5'd3, model[3]);
    check("bypass_commit_nb", nb_rd_data1, model[3]);
    // dropped write to reg 0 must not bypass
    wr_en = 1'b1; wr_addr = 5'd0; wr_lane_mask = 4'hF; wr_data = {LN{32'h77}};
    rd_addr1 = 5'd0; #1;
    check("bypass_zero_reg", rd_data1, '0);
    wr_en = 1'b0;

    // fill regs 1..31 with nonzero data
    for (int r = 1; r < NR; r++) begin
      v = {$urandom(), $urandom(), $urandom(), $urandom()} | W'(1);
      drv_write(AW'(r), 4'hF, v);
      model[r] = v;
    end
    sb_read("fill_reg31", 5'd31, model[31]);

    // clear handshake, with a dropped write and a repeated clr_req inside
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (c = 0; c < 100; c++) begin
      if (clr_busy) busy_cnt++;
      if (clr_done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c > 0 && !clr_busy && !clr_done) break;
      if (c == 5) begin
        wr_en = 1'b1; wr_addr = 5'd31; wr_lane_mask = 4'hF; wr_data = {LN{32'h1234}};
        rd_addr1 = 5'd31; #1;
        check("clr_no_bypass", rd_data1, model[31]);
        rd_addr1 = 5'd2; #1;
        check("clr_partial_reg2", rd_data1, '0);
      end
      if (c == 6) wr_en = 1'b0;
      clr_req = (c == 10);
      tick();
    end
    clr_req = 1'b0;
    check("clr_bound", W'(c < 100), W'(1));
    check("clr_busy_cycles", W'(busy_cnt), W'(NR));
    check("clr_done_pulses", W'(done_cnt), W'(1));
    check("clr_done_at", W'(done_at), W'(NR));
    for (int r = 0; r < NR; r++) model[r] = '0;
    for (int r = 0; r < NR; r++) sb_read($sformatf("clr_reg%0d", r), AW'(r), '0);

    // first cycle after DONE accepts a write
    drv_write(5'd31, 4'hF, {LN{32'h1234}});
    model[31] = {LN{32'h1234}};
    sb_read("post_clr_wr", 5'd31, model[31]);

    // reset in the middle of a clear
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("rclr_busy_start", W'(clr_busy), W'(1));
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rclr_busy_after_rst", W'(clr_busy), W'(0));
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (clr_done) done_cnt++;
      tick();
    end
    check("rclr_no_done", W'(done_cnt), W'(0));
    for (int r = 0; r < NR; r++) model[r] = '0;
    sb_read("rclr_reg31", 5'd31, model[31]);
    sb_read("rclr_reg7", 5'd7, model[7]);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("rclr_restart", W'(clr_busy), W'(1));
    for (c = 0; c < 100 && !clr_done; c++) tick();
    check("rclr_restart_done", W'(clr_done), W'(1));
    tick();
    check("rclr_idle", W'(dbg_state), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vreg_file_lanes.md
# vreg_file_lanes

Parametrised multi-lane vector register file for the VMIPS SIMD datapath, the successor to the single-word vector register file. Each register holds LANES elements of ELEM_W bits. Writes are per-lane masked. Reads are combinational and optionally bypass a same-cycle write. A built-in sequential clear engine zeroes the whole file one register per cycle on request, with a busy/done handshake to the control unit.

## Interface
Parameters:
- NUM_REGS, 32, number of vector registers (≥2)
- LANES, 4, elements per register
- ELEM_W, 32, bits per element
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports
- AW (localparam), $clog2(NUM_REGS), address width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- rd_addr1  in  AW  read port 1 address
- rd_addr2  in  AW  read port 2 address
- rd_data1  out  LANES*ELEM_W  read port 1 data; lane i = bits [i*ELEM_W +: ELEM_W]
- rd_data2  out  LANES*ELEM_W  read port 2 data
- wr_en  in  1  write request
- wr_addr  in  AW  write address
- wr_lane_mask  in  LANES  per-lane write enable
- wr_data  in  LANES*ELEM_W  write data
- clr_req  in  1  start full-file clear
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse when clear completes

## Operation
- Reset (rst=1 at posedge): all registers zeroed, FSM→IDLE, clear counter=0, clr_busy=0, clr_done=0. rst overrides every other input.
- Write: at posedge, if wr_en and state=IDLE, lane i of reg[wr_addr] ← wr_data lane i for each set wr_lane_mask[i]. Unmasked lanes hold.
- Dropped writes, with no side effects: wr_addr=0 when ZERO_REG=1; wr_addr ≥ NUM_REGS; any wr_en while clr_busy=1 or in DONE.
- Read (combinational): addr=0 with ZERO_REG=1 → all zero; addr ≥ NUM_REGS → all zero; otherwise stored value.
- Bypass (BYPASS=1): if a write would be accepted this cycle and rd_addrN=wr_addr, lanes with mask bit set return wr_data lanes. Other lanes return stored data. No bypass while clearing. BYPASS=0: reads show stored data only.
- Clear FSM:
  - IDLE: clr_req → CLEAR, counter=0.
  - CLEAR: each cycle zeroes all lanes of reg[counter] and increments counter. After reg NUM_REGS-1 is zeroed → DONE.
  - DONE: one cycle, then → IDLE.
- clr_busy=1 exactly in CLEAR. clr_done=1 exactly in DONE. Both are registered state decodes.
- clr_req is ignored in CLEAR and DONE; it does not queue.
- clr_req and wr_en in the same IDLE cycle: the write is performed, then erased by the clear.
- Reads during CLEAR return current contents, which are partially cleared.

## Timing
- Write latency: data is visible in storage from the cycle after the accepting edge. With BYPASS=1 it is visible on the read ports in the same cycle.
- Read path: purely combinational from rd_addrN, storage and the bypass inputs.
- Clear sequence, with clr_req sampled at edge N:
  - clr_busy rises after edge N.
  - Edges N+1 … N+NUM_REGS zero reg 0 … NUM_REGS-1.
  - After edge N+NUM_REGS: clr_busy=0, clr_done=1.
  - After edge N+NUM_REGS+1: clr_done=0, IDLE; writes are accepted again at this edge's following cycle.
- clr_busy stays high for exactly NUM_REGS cycles. The clear takes NUM_REGS+1 cycles from request to the first accepted write.
- Reset mid-clear: FSM→IDLE next edge, all registers zero, clr_busy=0, and no clr_done pulse.

## Test plan
- Reset/zero reg: pulse rst, write 0xFFFFFFFF to all lanes of reg 0 and reg 5 → rd reg0 = 0, rd reg5 = all-F; before any write, every register reads 0.
- Lane mask: reg 7 holds {4{0x11111111}}; write mask=4'b0101 with data {0xDDDDDDDD,0xCCCCCCCC,0xBBBBBBBB,0xAAAAAAAA} → reg 7 = {0x11111111,0xCCCCCCCC,0x11111111,0xAAAAAAAA}.
- Bypass: same cycle rd_addr1=wr_addr=3, mask=4'b0011, stored {4{0x5}}, wr_data {4{0x9}} → rd_data1 = {0x5,0x5,0x9,0x9} combinationally; with BYPASS=0 it reads {4{0x5}}.
- Clear handshake: fill regs 1..31 with nonzero data, assert clr_req 1 cycle → clr_busy high exactly 32 cycles, clr_done a single-cycle pulse, all regs then read 0; a second clr_req mid-clear causes no restart.
- Write during clear: wr_en to reg 31 at cycle 5 of CLEAR with data 0x1234 → write dropped, reg 31 = 0 after done; wr_en in the cycle after DONE is accepted.
- Reset mid-clear: rst at cycle 10 of CLEAR → next cycle clr_busy=0, clr_done never pulses, all regs 0, and a new clr_req is accepted.
